wisard_ram_accum: RTL and testbench
===================================

WISARD_RAM_ACCUM -- requirements
Module: wisard_ram_accum

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 5, meaning the width of one tuple address.
REQ-002 SHALL have parameter NUM_RAMS, default 16, meaning the number of RAM nodes, equal to the beats per frame.
REQ-003 SHALL have parameter SCORE_WIDTH, default 5, meaning the width of the score output; it SHALL be at least clog2(NUM_RAMS+1).
REQ-004 clk  input  1  single clock; all logic is rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 sop  input  1  marks the first beat of a frame; qualified by sink_valid.
REQ-007 sink_valid  input  1  the addr beat is valid this cycle.
REQ-008 addr  input  ADDRESS_WIDTH  tuple address for RAM node number beat_idx.
REQ-009 cfg_we  input  1  write strobe for the training/configuration port.
REQ-010 cfg_ram  input  clog2(NUM_RAMS)  RAM node index for the write.
REQ-011 cfg_addr  input  ADDRESS_WIDTH  bit address for the write.
REQ-012 cfg_data  input  1  bit value to write.
REQ-013 score  output  SCORE_WIDTH  count of hit bits in the last completed frame.
REQ-014 score_valid  output  1  one-cycle pulse; score is valid in the same cycle.
REQ-015 busy  output  1  high while a frame is being accumulated.
REQ-016 frame_err  output  1  one-cycle pulse when sop arrives mid-frame.

Function
REQ-017 Storage SHALL be NUM_RAMS x 2^ADDRESS_WIDTH bits, with one synchronous read (1-cycle latency) and one synchronous write per cycle.
REQ-018 FSM states: IDLE, ACCUM, FLUSH.
- IDLE->ACCUM on sop&&sink_valid.
- ACCUM->FLUSH on the beat with beat_idx==NUM_RAMS-1.
- FLUSH->IDLE after one cycle.
REQ-019 In IDLE, a beat with sink_valid=1 and sop=0 SHALL be ignored: no read, no count change.
REQ-020 A sop beat SHALL set beat_idx=0, clear the accumulator, and read ram[0][addr]; each subsequent valid beat SHALL increment beat_idx and read ram[beat_idx][addr].
REQ-021 Invalid cycles (sink_valid=0) inside a frame SHALL be gaps: no read, and beat_idx holds.
REQ-022 Each registered read bit SHALL be added to the accumulator one cycle after its beat; the add SHALL saturate at 2^SCORE_WIDTH-1.
REQ-023 score_valid SHALL pulse exactly 2 cycles after the last beat; score SHALL hold its value until the next score_valid.
REQ-024 busy SHALL be 1 in ACCUM and FLUSH, and 0 in IDLE.
REQ-025 On sop&&sink_valid in ACCUM:
- frame_err SHALL pulse;
- the current frame SHALL be discarded with no score_valid for it;
- this beat SHALL start a new frame (beat 0).
REQ-026 On sop&&sink_valid in FLUSH, the pending score SHALL still be emitted and the new frame SHALL start; frame_err SHALL stay 0.
REQ-027 When cfg_we writes the same bit as a concurrent read, the read SHALL return the old value; the write SHALL always complete.
REQ-028 NUM_RAMS==1 SHALL work: the sop beat is also the last beat.

Reset
REQ-029 rst=1 SHALL asynchronously force:
- state=IDLE, beat_idx=0, accumulator=0;
- score=0, score_valid=0, busy=0, frame_err=0.
REQ-030 Reset mid-frame SHALL abort the frame with no score_valid.
REQ-031 RAM contents SHALL NOT be cleared by reset, and are undefined until written.

Structure
REQ-032 Package wisard_pkg SHALL hold the FSM state enum, default ADDRESS_WIDTH/NUM_RAMS, and the clog2 helper.
REQ-033 Storage SHALL be a sub-module wisard_lut_ram: 1-bit wide, NUM_RAMS*2^ADDRESS_WIDTH deep, sync read port and write port.
REQ-034 The block SHALL consume the registered sop/sink_valid/addr of the input buffer stage directly, with no extra input register.

Verification
REQ-035 Write all bits to 1, then send a 16-beat frame -> score=16, score_valid pulses 2 cycles after beat 15.
REQ-036 Write only ram[3][7]=1 (rest 0); frame with addr=7 on every beat -> score=1.
REQ-037 Frame with 3-cycle sink_valid gaps after beats 4 and 9 -> same score as the gap-free frame; only the score_valid timing shifts.
REQ-038 sop at beat 8 of a frame -> frame_err pulse, no score for the first frame, a correct score for the second.
REQ-039 rst asserted at beat 5 -> all outputs 0 immediately; the next full frame scores correctly with no stale count.
REQ-040 cfg write of ram[0][2]=1 in the same cycle as the sop beat with addr=2 (old value 0) -> the frame counts 0 for node 0.

Source files
------------

// File: rtl/wisard_pkg.sv
// rtl/wisard_pkg.sv - shared types, defaults and width helpers for the WiSARD RAM accumulator
package wisard_pkg;

    localparam int DEF_ADDRESS_WIDTH = 5;
    localparam int DEF_NUM_RAMS      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Ceiling log2; clog2(1) is 0
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Width of a RAM node index, never below one bit so NUM_RAMS==1 still has a port
    function automatic int ram_idx_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/wisard_lut_ram.sv
// rtl/wisard_lut_ram.sv - 1-bit wide LUT storage with one sync read and one sync write port
module wisard_lut_ram #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic              rdata
);

    logic mem [DEPTH];

    // Write and read share the edge; a read of the bit being written returns the old value
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/wisard_ram_accum.sv
// rtl/wisard_ram_accum.sv - WiSARD discriminator: per-beat RAM node lookup and hit-count scoring
module wisard_ram_accum
    import wisard_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int NUM_RAMS      = DEF_NUM_RAMS,
    parameter int SCORE_WIDTH   = 5
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 sop,
    input  logic                                 sink_valid,
    input  logic [ADDRESS_WIDTH-1:0]             addr,
    input  logic                                 cfg_we,
    input  logic [ram_idx_width(NUM_RAMS)-1:0]   cfg_ram,
    input  logic [ADDRESS_WIDTH-1:0]             cfg_addr,
    input  logic                                 cfg_data,
    output logic [SCORE_WIDTH-1:0]               score,
    output logic                                 score_valid,
    output logic                                 busy,
    output logic                                 frame_err
);

    localparam int RW    = ram_idx_width(NUM_RAMS);
    localparam int LA    = RW + ADDRESS_WIDTH;
    localparam int DEPTH = NUM_RAMS << ADDRESS_WIDTH;
    localparam logic [RW-1:0] LAST_IDX = RW'(NUM_RAMS - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [RW-1:0]          beat_idx;
    logic [RW-1:0]          rd_ram;
    logic                   start;
    logic                   rd_en;
    logic                   rd_bit;
    logic                   rd_valid;
    logic [SCORE_WIDTH-1:0] acc;
    logic [SCORE_WIDTH-1:0] acc_sum;

    function automatic logic [SCORE_WIDTH-1:0] sat_add(input logic [SCORE_WIDTH-1:0] a,
                                                       input logic b);
        logic [SCORE_WIDTH:0] s;
        s = {1'b0, a} + {{SCORE_WIDTH{1'b0}}, b};
        return s[SCORE_WIDTH] ? {SCORE_WIDTH{1'b1}} : s[SCORE_WIDTH-1:0];
    endfunction

    // Beat acceptance, RAM read select and next-state; a sop beat restarts from any state
    always_comb begin
        start     = sink_valid && sop;
        rd_en     = start || ((state == ST_ACCUM) && sink_valid);
        rd_ram    = start ? '0 : beat_idx + RW'(1);
        acc_sum   = sat_add(acc, rd_bit);
        state_nxt = state;
        if (rd_en) begin
            state_nxt = (rd_ram == LAST_IDX) ? ST_FLUSH : ST_ACCUM;
        end else if (state == ST_FLUSH) begin
            state_nxt = ST_IDLE;
        end
    end

    wisard_lut_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (LA)
    ) u_lut_ram (
        .clk   (clk),
        .we    (cfg_we),
        .waddr ({cfg_ram, cfg_addr}),
        .wdata (cfg_data),
        .re    (rd_en),
        .raddr ({rd_ram, addr}),
        .rdata (rd_bit)
    );

    // Frame sequencing and hit accumulation; the last read bit is folded in while in FLUSH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            beat_idx    <= '0;
            acc         <= '0;
            rd_valid    <= 1'b0;
            score       <= '0;
            score_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            rd_valid    <= rd_en;
            score_valid <= (state == ST_FLUSH);
            frame_err   <= start && (state == ST_ACCUM);
            if (rd_en) begin
                beat_idx <= rd_ram;
            end
            if (start) begin
                acc <= '0;
            end else if (rd_valid) begin
                acc <= acc_sum;
            end
            if (state == ST_FLUSH) begin
                score <= acc_sum;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_wisard_ram_accum.sv
// tb/tb_wisard_ram_accum.sv - directed table-driven bench for wisard_ram_accum
module tb_wisard_ram_accum;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sop = 1'b0;
    logic       sink_valid = 1'b0;
    logic [4:0] addr = '0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_ram = '0;
    logic [4:0] cfg_addr = '0;
    logic       cfg_data = 1'b0;
    logic [4:0] score;
    logic       score_valid;
    logic       busy;
    logic       frame_err;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int last_beat_cyc = 0;
    int fe_count = 0;
    int sv_scores[$];
    int sv_cycles[$];

    typedef struct {
        string name;
        int    mode;
        int    c;
        int    ov_beat;
        int    ov_addr;
        bit    gaps;
        int    exp;
    } vec_t;

    vec_t vecs[6];

    wisard_ram_accum #(
        .ADDRESS_WIDTH (5),
        .NUM_RAMS      (16),
        .SCORE_WIDTH   (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sop         (sop),
        .sink_valid  (sink_valid),
        .addr        (addr),
        .cfg_we      (cfg_we),
        .cfg_ram     (cfg_ram),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .score       (score),
        .score_valid (score_valid),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (score_valid) begin
                sv_scores.push_back(int'(score));
                sv_cycles.push_back(cyc);
            end
            if (frame_err) fe_count++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill_all(input logic v);
        cfg_we   = 1'b1;
        cfg_data = v;
        for (int r = 0; r < 16; r++) begin
            for (int a = 0; a < 32; a++) begin
                cfg_ram  = 4'(r);
                cfg_addr = 5'(a);
                step();
            end
        end
        cfg_we = 1'b0;
    endtask

    task automatic cfg_write(input int r, input int a, input logic d);
        cfg_we   = 1'b1;
        cfg_ram  = 4'(r);
        cfg_addr = 5'(a);
        cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    function automatic int addr_of(input int mode, input int c, input int ov_beat,
                                   input int ov_addr, input int b);
        if (b == ov_beat) return ov_addr;
        return (mode == 0) ? b : c;
    endfunction

    // Drives nbeats beats starting with sop; any pending cfg write is dropped after beat 0
    task automatic send_frame(input int mode, input int c, input int ov_beat,
                              input int ov_addr, input bit gaps, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            sop           = (b == 0);
            sink_valid    = 1'b1;
            addr          = 5'(addr_of(mode, c, ov_beat, ov_addr, b));
            last_beat_cyc = cyc;
            step();
            cfg_we = 1'b0;
            if (gaps && (b == 4 || b == 9)) begin
                sop        = 1'b0;
                sink_valid = 1'b0;
                repeat (3) step();
            end
        end
        sop        = 1'b0;
        sink_valid = 1'b0;
    endtask

    // Waits (bounded) until total score pulses reaches want, then confirms no extra pulses
    task automatic wait_scores(input string name, input int want);
        int n;
        n = 0;
        while (sv_scores.size() < want && n < 40) begin
            step();
            n++;
        end
        repeat (3) step();
        chk({name, "_pulses"}, sv_scores.size(), want);
    endtask

    task automatic single_frame(input string name, input int mode, input int c,
                                input int ov_beat, input int ov_addr, input bit gaps,
                                input int exp);
        int base;
        base = sv_scores.size();
        send_frame(mode, c, ov_beat, ov_addr, gaps, 16);
        wait_scores(name, base + 1);
        if (sv_scores.size() > base) begin
            chk({name, "_score"}, sv_scores[base], exp);
            chk({name, "_latency"}, sv_cycles[base] - last_beat_cyc, 2);
        end
    endtask

    initial begin
        int base;
        int fe_base;

        vecs[0] = '{"diag",      0, 0,  -1, 0, 1'b0, 8};
        vecs[1] = '{"const7",    1, 7,  -1, 0, 1'b0, 1};
        vecs[2] = '{"diag_gaps", 0, 0,  -1, 0, 1'b1, 8};
        vecs[3] = '{"const0",    1, 0,  -1, 0, 1'b0, 1};
        vecs[4] = '{"diag_ov3",  0, 0,   3, 7, 1'b0, 9};
        vecs[5] = '{"const31",   1, 31, -1, 0, 1'b0, 0};

        // Reset state
        step();
        step();
        chk("rst_score", int'(score), 0);
        chk("rst_score_valid", int'(score_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        rst = 1'b0;
        step();

        // All ones: every beat hits
        fill_all(1'b1);
        single_frame("all_ones", 0, 0, -1, 0, 1'b0, 16);

        // Only ram[3][7] set
        fill_all(1'b0);
        cfg_write(3, 7, 1'b1);
        single_frame("single_bit", 1, 7, -1, 0, 1'b0, 1);

        // Diagonal pattern on even nodes: ram[r][r]=1 for r even
        for (int r = 0; r < 16; r += 2) cfg_write(r, r, 1'b1);

        // Non-sop beats in IDLE are ignored
        base = sv_scores.size();
        sop = 1'b0;
        sink_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            addr = 5'(i);
            step();
            chk("idle_ignore_busy", int'(busy), 0);
        end
        sink_valid = 1'b0;
        repeat (4) step();
        chk("idle_ignore_pulses", sv_scores.size(), base);

        for (int i = 0; i < 6; i++) begin
            single_frame(vecs[i].name, vecs[i].mode, vecs[i].c, vecs[i].ov_beat,
                         vecs[i].ov_addr, vecs[i].gaps, vecs[i].exp);
        end

        // sop at beat 8 restarts the frame with frame_err and no score for the first
        base    = sv_scores.size();
        fe_base = fe_count;
        send_frame(0, 0, -1, 0, 1'b0, 8);
        send_frame(0, 0, -1, 0, 1'b0, 16);
        wait_scores("restart", base + 1);
        chk("restart_frame_err", fe_count - fe_base, 1);
        if (sv_scores.size() > base) begin
            chk("restart_score", sv_scores[base], 8);
            chk("restart_latency", sv_cycles[base] - last_beat_cyc, 2);
        end

        // sop during FLUSH: both scores emitted, no frame_err
        base    = sv_scores.size();
        fe_base = fe_count;
        send_frame(0, 0, -1, 0, 1'b0, 16);
        send_frame(1, 7, -1, 0, 1'b0, 16);
        wait_scores("flush_sop", base + 2);
        chk("flush_sop_frame_err", fe_count - fe_base, 0);
        if (sv_scores.size() > base + 1) begin
            chk("flush_sop_score_a", sv_scores[base], 8);
            chk("flush_sop_score_b", sv_scores[base + 1], 1);
            chk("flush_sop_latency_b", sv_cycles[base + 1] - last_beat_cyc, 2);
        end

        // Reset at beat 5 clears outputs at once and aborts the frame
        base = sv_scores.size();
        send_frame(0, 0, -1, 0, 1'b0, 5);
        chk("mid_frame_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_score", int'(score), 0);
        chk("async_rst_score_valid", int'(score_valid), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_frame_err", int'(frame_err), 0);
        step();
        step();
        rst = 1'b0;
        repeat (4) step();
        chk("rst_abort_pulses", sv_scores.size(), base);
        single_frame("after_rst", 0, 0, -1, 0, 1'b0, 8);

        // Write of ram[0][2] concurrent with the sop read of it returns the old value
        cfg_we   = 1'b1;
        cfg_ram  = 4'd0;
        cfg_addr = 5'd2;
        cfg_data = 1'b1;
        single_frame("wr_collide", 1, 2, -1, 0, 1'b0, 1);
        single_frame("wr_landed", 1, 2, -1, 0, 1'b0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
